dcache_assoc: RTL

//  Blocking N-way set-associative write-back data cache, one word per line, between the CPU MEM stage and the memory bus.

---
 rtl/dcache_assoc_if.sv | 39 +++
 rtl/dcache_assoc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc_if.sv
// rtl/dcache_assoc_if.sv - CPU request/response and memory bus bundle for dcache_assoc
interface dcache_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic [4:0]        req_rd;
    logic              resp_valid;
    logic [4:0]        resp_rd;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, req_rd,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, resp_valid, resp_rd, resp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, req_rd,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, resp_valid, resp_rd, resp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - blocking N-way set-associative write-back data cache, one word per line
// Optional hit/miss/write-back counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_assoc #(
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_assoc_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] wb_cnt
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int BE_W  = DATA_W / 8;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, EVICT, FILL_REQ, FILL_WAIT, RESP} state_t;

    state_t                        state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]     valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][WAY_W-1:0]    rr_q, rr_d;
    logic [TAG_W-1:0]              tag_q  [SETS][WAYS];
    logic [DATA_W-1:0]             data_q [SETS][WAYS];

    logic                          req_we_q, req_we_d;
    logic [IDX_W-1:0]              req_idx_q, req_idx_d;
    logic [TAG_W-1:0]              req_tag_q, req_tag_d;
    logic [DATA_W-1:0]             req_wdata_q, req_wdata_d;
    logic [BE_W-1:0]               req_be_q, req_be_d;
    logic [4:0]                    req_rd_q, req_rd_d;
    logic [WAY_W-1:0]              victim_q, victim_d;

    logic                          resp_valid_q, resp_valid_d;
    logic [4:0]                    resp_rd_q, resp_rd_d;
    logic [DATA_W-1:0]             resp_rdata_q, resp_rdata_d;
    logic                          mem_req_valid_q, mem_req_valid_d;
    logic                          mem_req_we_q, mem_req_we_d;
    logic [ADDR_W-1:0]             mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0]             mem_req_wdata_q, mem_req_wdata_d;

    logic                          arr_we;
    logic [IDX_W-1:0]              arr_idx;
    logic [WAY_W-1:0]              arr_way;
    logic [TAG_W-1:0]              arr_tag;
    logic [DATA_W-1:0]             arr_data;

    logic [IDX_W-1:0]              in_idx;
    logic [TAG_W-1:0]              in_tag;
    logic                          hit, inv_found;
    logic [WAY_W-1:0]              hit_way, inv_way, victim;
    logic                          unused_addr_lsb;

    assign in_idx          = bus.req_addr[IDX_W+1:2];
    assign in_tag          = bus.req_addr[ADDR_W-1:IDX_W+2];
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    // Lookup on the live request: first matching way, and lowest-index free way for fills.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[in_idx][w] && tag_q[in_idx][w] == in_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[in_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : rr_q[in_idx];
    end

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        rr_d            = rr_q;
        req_we_d        = req_we_q;
        req_idx_d       = req_idx_q;
        req_tag_d       = req_tag_q;
        req_wdata_d     = req_wdata_q;
        req_be_d        = req_be_q;
        req_rd_d        = req_rd_q;
        victim_d        = victim_q;
        resp_valid_d    = 1'b0;
        resp_rd_d       = '0;
        resp_rdata_d    = '0;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        arr_we          = 1'b0;
        arr_idx         = req_idx_q;
        arr_way         = victim_q;
        arr_tag         = req_tag_q;
        arr_data        = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_we_d    = bus.req_we;
                    req_idx_d   = in_idx;
                    req_tag_d   = in_tag;
                    req_wdata_d = bus.req_wdata;
                    req_be_d    = bus.req_be;
                    req_rd_d    = bus.req_rd;
                    if (hit) begin
                        resp_valid_d = 1'b1;
                        resp_rd_d    = bus.req_rd;
                        if (bus.req_we) begin
                            arr_we   = 1'b1;
                            arr_idx  = in_idx;
                            arr_way  = hit_way;
                            arr_tag  = in_tag;
                            arr_data = merge(data_q[in_idx][hit_way], bus.req_wdata, bus.req_be);
                            dirty_d[in_idx][hit_way] = dirty_q[in_idx][hit_way] | (|bus.req_be);
                        end else begin
                            resp_rdata_d = data_q[in_idx][hit_way];
                        end
                    end else begin
                        victim_d = victim;
                        if (!inv_found) rr_d[in_idx] = rr_q[in_idx] + 1'b1;
                        valid_d[in_idx][victim] = 1'b0;
                        dirty_d[in_idx][victim] = 1'b0;
                        mem_req_valid_d = 1'b1;
                        if (!inv_found && dirty_q[in_idx][victim]) begin
                            state_d         = EVICT;
                            mem_req_we_d    = 1'b1;
                            mem_req_addr_d  = {tag_q[in_idx][victim], in_idx, 2'b00};
                            mem_req_wdata_d = data_q[in_idx][victim];
                        end else begin
                            state_d         = FILL_REQ;
                            mem_req_we_d    = 1'b0;
                            mem_req_addr_d  = {in_tag, in_idx, 2'b00};
                            mem_req_wdata_d = '0;
                        end
                    end
                end
            end
            EVICT: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = FILL_REQ;
                end
            end
            FILL_REQ: begin
                // After a write-back the bus idles one cycle before the fetch is raised.
                if (!mem_req_valid_q) begin
                    mem_req_valid_d = 1'b1;
                    mem_req_we_d    = 1'b0;
                    mem_req_addr_d  = {req_tag_q, req_idx_q, 2'b00};
                    mem_req_wdata_d = '0;
                end else if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    arr_we   = 1'b1;
                    arr_data = req_we_q ? merge(bus.mem_rsp_data, req_wdata_q, req_be_q)
                                        : bus.mem_rsp_data;
                    valid_d[req_idx_q][victim_q] = 1'b1;
                    dirty_d[req_idx_q][victim_q] = req_we_q && (|req_be_q);
                    resp_valid_d = 1'b1;
                    resp_rd_d    = req_rd_q;
                    resp_rdata_d = req_we_q ? '0 : bus.mem_rsp_data;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            rr_q            <= '0;
            req_we_q        <= 1'b0;
            req_idx_q       <= '0;
            req_tag_q       <= '0;
            req_wdata_q     <= '0;
            req_be_q        <= '0;
            req_rd_q        <= '0;
            victim_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_rd_q       <= '0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            rr_q            <= rr_d;
            req_we_q        <= req_we_d;
            req_idx_q       <= req_idx_d;
            req_tag_q       <= req_tag_d;
            req_wdata_q     <= req_wdata_d;
            req_be_q        <= req_be_d;
            req_rd_q        <= req_rd_d;
            victim_q        <= victim_d;
            resp_valid_q    <= resp_valid_d;
            resp_rd_q       <= resp_rd_d;
            resp_rdata_q    <= resp_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
        end
    end

    // Tag/data storage is never reset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (rst_n && arr_we) begin
            tag_q[arr_idx][arr_way]  <= arr_tag;
            data_q[arr_idx][arr_way] <= arr_data;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_we    = mem_req_we_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_req_wdata = mem_req_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
    logic        acc_idle;

    always_comb begin
        acc_idle   = (state_q == IDLE) && bus.req_valid;
        hit_cnt_d  = hit_cnt_q  + 32'(acc_idle && hit);
        miss_cnt_d = miss_cnt_q + 32'(acc_idle && !hit);
        wb_cnt_d   = wb_cnt_q   + 32'((state_q == EVICT) && bus.mem_req_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif
endmodule
